// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and constants: bubble encodings, per-stage
// payload structs and the main-register load selector used by pipe_stage_reg.
package pipe_pkg;

  localparam logic [31:0] PIPE_NOP_INST = 32'h00000013;
  localparam logic [31:0] PIPE_RESET_PC = 32'h00400000;
  localparam logic [3:0]  PIPE_ACC_NONE = 4'hF;
  localparam logic [3:0]  PIPE_BR_NONE  = 4'hF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [3:0]  dmem_type;
    logic [3:0]  br_type;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [3:0]  dmem_type;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] wb_data;
    logic [4:0]  rd;
  } mem_wb_t;

  // Bubbles that make a flushed stage look like a NOP at the reset PC.
  localparam if_id_t IF_ID_BUBBLE = '{pc: PIPE_RESET_PC, inst: PIPE_NOP_INST};
  localparam id_ex_t ID_EX_BUBBLE = '{pc: PIPE_RESET_PC, inst: PIPE_NOP_INST,
                                      rs1_val: '0, rs2_val: '0, imm: '0,
                                      dmem_type: PIPE_ACC_NONE, br_type: PIPE_BR_NONE};

  typedef enum logic [1:0] {
    LOAD_NONE,
    LOAD_IN,
    LOAD_SKID,
    LOAD_BUBBLE
  } main_sel_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry holding register with valid flag; catches one payload while
// the main stage register is stalled.
module pipe_skid_buf #(
  parameter int DATA_W = 160
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (clear || unload) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end
    if (load && !clear) begin
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // NOTE: the payload flops carry no reset; valid_q alone says whether they hold anything meaningful.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, global enable and
// saturating stall counter. Define PIPE_SKID_EN to add a skid entry that makes in_ready registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 160,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic              out_valid_d, out_valid_q;
  logic [DATA_W-1:0] out_data_d, out_data_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              in_xfer, out_xfer, main_free, stall;
  main_sel_e         main_sel;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;
  assign main_free = ~out_valid_q | out_ready;
  assign stall     = en & out_valid_q & ~out_ready;

`ifdef PIPE_SKID_EN
  // Ready depends only on registered skid state, cutting the out_ready->in_ready path.
  assign in_ready = rst_n & en & ~skid_valid;

  pipe_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (en & ~flush & in_xfer & ~main_free),
    .unload  (en & ~flush & skid_valid & main_free),
    .clear   (en & flush),
    .in_data (in_data),
    .valid   (skid_valid),
    .data    (skid_data)
  );
`else
  assign in_ready   = rst_n & en & main_free;
  assign skid_valid = 1'b0;
  assign skid_data  = BUBBLE_DATA;
`endif

  always_comb begin
    main_sel = LOAD_NONE;
    if (en) begin
      if (flush)               main_sel = LOAD_BUBBLE;
      else if (main_free) begin
        // A waiting skid entry is older than anything upstream offers.
        if (skid_valid)        main_sel = LOAD_SKID;
        else if (in_xfer)      main_sel = LOAD_IN;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (main_sel)
      LOAD_BUBBLE: begin out_valid_d = 1'b0; out_data_d = BUBBLE_DATA; end
      LOAD_SKID:   begin out_valid_d = 1'b1; out_data_d = skid_data;   end
      LOAD_IN:     begin out_valid_d = 1'b1; out_data_d = in_data;     end
      default:     if (en && out_xfer) out_valid_d = 1'b0;
    endcase
    stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= BUBBLE_DATA;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand sequences
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int             DW   = 32;
  localparam int             CW   = 4;
  localparam int             CMAX = 15;
  localparam logic [DW-1:0]  BUB  = 32'hBB00_0013;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cycles;

  pipe_stage_reg #(.DATA_W(DW), .BUBBLE_DATA(BUB), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: stage contents as a FIFO of capacity 1 (or 2 with skid).
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_held;
  int            m_cnt;

  function automatic bit m_rdy();
    if (!en) return 1'b0;
    if (SKID) return m_q.size() < 2;
    return (m_q.size() == 0) || out_ready;
  endfunction

  function automatic logic [DW-1:0] m_data();
    return (m_q.size() > 0) ? m_q[0] : m_held;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_held = BUB;
    m_cnt  = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),     64'(m_rdy()));
    check({tag, "_out_valid"}, 64'(out_valid),    64'(m_q.size() > 0));
    check({tag, "_out_data"},  64'(out_data),     64'(m_data()));
    check({tag, "_stall"},     64'(stall_cycles), 64'(m_cnt));
  endtask

  task automatic advance_model();
    bit rdy, v;
    rdy = m_rdy();
    v   = m_q.size() > 0;
    if (!en) return;
    if (v && !out_ready && m_cnt != CMAX) m_cnt++;
    if (flush) begin
      m_q.delete();
      m_held = BUB;
      return;
    end
    if (v && out_ready) m_held = m_q.pop_front();
    if (in_valid && rdy) m_q.push_back(in_data);
  endtask

  task automatic drive(input bit e, input bit f, input bit iv, input logic [DW-1:0] d, input bit ordy);
    @(negedge clk);
    en = e; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic step(input string tag, input bit e, input bit f, input bit iv,
                      input logic [DW-1:0] d, input bit ordy);
    drive(e, f, iv, d, ordy);
    compare_model(tag);
    advance_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid),    64'(0));
    check({tag, "_out_data"},  64'(out_data),     64'(BUB));
    check({tag, "_stall"},     64'(stall_cycles), 64'(0));
    check({tag, "_in_ready"},  64'(in_ready),     64'(0));
  endtask

  // Reset asserted between edges with a payload on offer; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    en = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rst_hold");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  typedef struct {
    bit            en;
    bit            fl;
    bit            iv;
    logic [DW-1:0] d;
    bit            ordy;
    bit            ev;
    logic [DW-1:0] ed;
    bit            erdy;
    int            est;
  } vec_t;

  vec_t          tbl[$];
  int            acc, n_emit;
  logic [DW-1:0] p;
  logic [DW-1:0] emitted[$];

  initial begin
    // Expected fields are the outputs seen after inputs settle, before that row's edge.
    tbl.push_back('{1, 0, 1, 32'd1, 1, 0, BUB, 1, 0});
    for (int k = 1; k <= 7; k++) tbl.push_back('{1, 0, 1, 32'(k + 1), 1, 1, 32'(k), 1, 0});
    tbl.push_back('{1, 0, 0, 32'd0,  1, 1, 32'd8,  1, 0});
    tbl.push_back('{1, 0, 0, 32'd0,  1, 0, 32'd8,  1, 0});
    tbl.push_back('{1, 0, 1, 32'h10, 1, 0, 32'd8,  1, 0});
    tbl.push_back('{1, 1, 1, 32'h11, 0, 1, 32'h10, SKID, 0});
    tbl.push_back('{1, 0, 0, 32'd0,  1, 0, BUB,    1, 1});
    tbl.push_back('{1, 0, 1, 32'h21, 1, 0, BUB,    1, 1});
    tbl.push_back('{1, 0, 1, 32'h22, 1, 1, 32'h21, 1, 1});
    tbl.push_back('{0, 0, 1, 32'h23, 1, 1, 32'h22, 0, 1});
    tbl.push_back('{0, 1, 1, 32'h23, 1, 1, 32'h22, 0, 1});
    tbl.push_back('{0, 0, 1, 32'h23, 1, 1, 32'h22, 0, 1});
    tbl.push_back('{1, 0, 1, 32'h23, 1, 1, 32'h22, 1, 1});
    tbl.push_back('{1, 0, 0, 32'd0,  1, 1, 32'h23, 1, 1});
    tbl.push_back('{1, 0, 0, 32'd0,  1, 0, 32'h23, 1, 1});

    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      check($sformatf("vec%0d_valid", i), 64'(out_valid),    64'(tbl[i].ev));
      check($sformatf("vec%0d_data", i),  64'(out_data),     64'(tbl[i].ed));
      check($sformatf("vec%0d_ready", i), 64'(in_ready),     64'(tbl[i].erdy));
      check($sformatf("vec%0d_stall", i), 64'(stall_cycles), 64'(tbl[i].est));
      compare_model("vec_model");
      advance_model();
    end

    // Backpressure: 5 stalled cycles with upstream always offering a payload.
    do_reset();
    step("bp_fill", 1, 0, 1, 32'h31, 1);
    acc = 1;
    p   = 32'h32;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, p, 0);
      compare_model("bp_stall");
      check("bp_hold_data", 64'(out_data), 64'h31);
      if (in_ready) begin
        acc++;
        p++;
      end
      advance_model();
    end
    emitted.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, '0, 1);
      if (i == 0) check("bp_stall_count", 64'(stall_cycles), 64'(5));
      compare_model("bp_drain");
      if (out_valid) emitted.push_back(out_data);
      advance_model();
    end
    check("bp_accepted", 64'(acc), 64'(SKID ? 2 : 1));
    n_emit = emitted.size();
    check("bp_emitted", 64'(n_emit), 64'(SKID ? 2 : 1));
    if (n_emit > 0) check("bp_first", 64'(emitted[0]), 64'h31);
    if (n_emit > 1) check("bp_second", 64'(emitted[1]), 64'h32);

    // Saturation: counter is 4 bits wide here, so 20 stalled cycles pin it at 15.
    do_reset();
    step("sat_fill", 1, 0, 1, 32'h41, 1);
    for (int i = 0; i < 20; i++) step("sat_stall", 1, 0, 0, '0, 0);
    drive(1, 0, 0, '0, 0);
    check("sat_value", 64'(stall_cycles), 64'(CMAX));
    advance_model();
    drive(1, 0, 0, '0, 0);
    check("sat_holds", 64'(stall_cycles), 64'(CMAX));
    advance_model();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0,
           $urandom,
           $urandom_range(0, 9) < 7);
    end

    // Reset in the middle of a transfer, then a clean first transfer afterwards.
    do_reset();
    step("post_rst_push", 1, 0, 1, 32'h55, 1);
    step("post_rst_seen", 1, 0, 0, '0, 1);
    step("post_rst_idle", 1, 0, 0, '0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake. It replaces hand-written per-stage registers such as IF/ID, ID/EX, EX/MEM and MEM/WB in the pipelined CPU. Each stage boundary carries its own packed payload vector, and stall, flush and global enable are handled uniformly. An optional skid entry breaks the combinational ready path between stages. A saturating stall-cycle counter supports performance debug.

## Interface
Parameters:
- `DATA_W`, default 160: packed payload width in bits, at least 1.
- `BUBBLE_DATA`, default `'0`: payload value loaded on reset and flush. The CPU instantiation supplies a NOP-encoded bubble (pc 0x00400000, inst 0x00000013, dmem/br type 4'hF).
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: global enable. While low, all state freezes and flush is ignored.
- `flush`, input, 1: kills held and incoming entries. Sampled only when `en` is high.
- `in_valid`, input, 1: upstream presents a payload.
- `in_ready`, output, 1: stage accepts the payload this cycle.
- `in_data`, input, DATA_W: upstream payload.
- `out_valid`, output, 1: downstream payload is valid. This replaces the old per-stage commit bit.
- `out_ready`, input, 1: downstream consumes the payload this cycle.
- `out_data`, output, DATA_W: registered payload.
- `stall_cycles`, output, CNT_W: count of cycles with `out_valid & ~out_ready & en`. Saturates at all-ones.

## Operation
- Transfer rule: a transfer occurs on a rising edge when both valid and ready are high. This holds on both sides.
- Main register: captures `in_data` on an input transfer.
  - If there is no input transfer and an output transfer occurs, `out_valid` falls to 0.
  - While `out_valid & ~out_ready`, `out_data` is held stable and must not change.
- Flush, when `en` and `flush` are both high:
  - `out_valid` becomes 0, the skid entry becomes empty, and `out_data` becomes `BUBBLE_DATA`.
  - Any input accepted in the same cycle is discarded.
  - Flush has priority over stall and over transfers.
- Enable: with `en` low, `in_ready` is 0, registers hold, and the counter holds. `out_valid` still shows the held entry.
- Reset, while `rst_n` is low (asynchronous, overrides everything):
  - `out_valid` is 0, `out_data` is `BUBBLE_DATA`, the skid entry is empty, `stall_cycles` is 0, and `in_ready` is 0.
- Reset asserted mid-transfer discards the in-flight payload. No partial update is allowed.
- Valid rule: `out_valid` never rises without a preceding input transfer. Bubbles are never presented as valid.

## Timing
- Latency: 1 cycle from the input transfer edge to `out_valid`/`out_data`. Throughput: 1 transfer per cycle.
- Without skid: `in_ready = en & (~out_valid | out_ready)`. This is combinational from `out_ready`.
- With skid, `in_ready = en & ~skid_valid`, which is purely registered. Skid behaviour:
  - A payload that arrives while the main register is full and `out_ready` is low goes into the skid entry.
  - On the next output transfer, the skid entry moves to the main register and `out_valid` stays 1.
  - Total storage is 2 entries. `in_ready` drops 1 cycle after the skid entry fills.
- Simultaneous input and output transfer with the skid empty: the main register loads the new data and `out_valid` stays 1.
- Counter: increments on the same edge as the stall condition and is visible on the next cycle. At all-ones it holds.

## Configuration
- `PIPE_SKID_EN` defined: the skid entry is compiled in, and `in_ready` has no combinational path from `out_ready`.
- `PIPE_SKID_EN` undefined: there is a single register, `in_ready` depends combinationally on `out_ready`, and there is zero skid area. The CPU's default build leaves this undefined.

## Structure
- Shared package `pipe_pkg`:
  - `PIPE_NOP_INST` = 32'h00000013.
  - `PIPE_RESET_PC` = 32'h00400000.
  - `PIPE_ACC_NONE` = 4'hF and `PIPE_BR_NONE` = 4'hF.
  - Per-stage packed struct typedefs (e.g. `id_ex_t`), so that `DATA_W = $bits(id_ex_t)`.
- One sub-module, `pipe_skid_buf`: a single-entry holding register with its valid flag. It is instantiated only under `PIPE_SKID_EN`.

## Test plan
- Reset: hold `rst_n` = 0 with `in_valid` = 1 and `in_data` = 0xA5. Require `out_valid` = 0, `out_data` = `BUBBLE_DATA`, `stall_cycles` = 0 and `in_ready` = 0. After release, the first transfer appears 1 cycle later.
- Streaming: drive 8 back-to-back payloads 1..8 with `out_ready` = 1. Require `out_data` = 1..8 on consecutive cycles and `out_valid` continuously 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles while `out_valid` = 1. Require `out_data` stable and `stall_cycles` = 5.
  - With skid: exactly 2 payloads are accepted and emitted in order.
  - Without skid: 1 payload is accepted.
- Flush: assert `flush` with a held entry and a concurrent `in_valid`. The next cycle must show `out_valid` = 0 and `out_data` = `BUBBLE_DATA`, with no payload ever emitted.
- Enable: `en` = 0 for 3 cycles mid-stream, with `flush` = 1 during one of them. Require all state held, `in_ready` = 0, the flush ignored, and streaming resuming without loss.
- Saturation: with `CNT_W` = 4, stall for 20 cycles. Require `stall_cycles` = 15 and holding.
